mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters: instruction fetch (IF) and data load/store (D).
- Sits between the pipeline's fetch/MEM stages and a unified instruction/data RAM.
- Allows one outstanding transaction at a time, using a valid/ready request handshake and a single-cycle response pulse.
- Pipeline stalls are driven from the deasserted ready signals.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata. Legal range 1..8; other values are an elaboration error.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous reset, active-high
- if_req_valid  in  1  IF read request
- if_req_ready  out  1  IF request accepted this cycle
- if_req_addr  in  AW  IF byte address
- if_rsp_valid  out  1  IF read data valid (one-cycle pulse)
- if_rsp_data  out  DW  IF read data
- d_req_valid  in  1  D request
- d_req_ready  out  1  D request accepted this cycle
- d_req_we  in  1  1 = write, 0 = read
- d_req_strb  in  DW/8  byte write strobes
- d_req_addr  in  AW  D byte address
- d_req_wdata  in  DW  write data
- d_rsp_valid  out  1  D response (read data or write ack), one-cycle pulse
- d_rsp_data  out  DW  D read data; 0 for writes
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_strb  out  DW/8  memory byte strobes
- mem_addr  out  AW  memory byte address (passed through unchanged)
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en
- arb_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset:
  - Async on areset high: state=IDLE, lat_cnt=0, owner=IF, rr_last=IF.
  - All outputs 0.
  - Reset mid-transaction drops it; late mem_rdata is ignored and no rsp pulse is produced.
- FSM:
  - IDLE: req_ready=1 for the arbitration winner only, and only when its valid=1 (ready is combinational from valid). On handshake, latch owner, we, strb, addr, wdata, then -> ISSUE.
  - ISSUE: mem_en=1 for exactly one cycle with latched command; lat_cnt=MEM_LAT-1; -> WAIT.
  - WAIT: when lat_cnt==0, capture mem_rdata (read) or 0 (write) into rsp_data reg, -> RESP; else decrement. With MEM_LAT=1 WAIT lasts one cycle.
  - RESP: owner's rsp_valid=1 for one cycle, the other rsp_valid=0; -> IDLE.
- Timing:
  - Handshake at T gives mem_en at T+1, rdata at T+1+MEM_LAT, rsp_valid at T+2+MEM_LAT.
  - Next acceptance earliest at T+3+MEM_LAT.
  - Throughput: one transaction per MEM_LAT+3 cycles.
- Requester rules:
  - Hold valid and payload stable until ready.
  - Requesters may deassert valid before ready; no transaction results.
  - IF requests are treated as reads regardless of other inputs (mem_we=0, mem_strb=0).
- Arbitration (default): fixed priority, D over IF, because D is the older instruction. If both are valid in IDLE, D wins and if_req_ready=0.
- rsp_data holds its value until the next RESP capture; it is don't-care when rsp_valid=0.
- mem_* outputs are 0 in every state except ISSUE.

Optional Feature:
- Macro ARB_RR_EN.
- Defined:
  - Round-robin arbitration. rr_last records the last granted requester.
  - When both are valid, grant the one not equal to rr_last.
  - rr_last updates on every handshake and resets to IF, so the first contended grant goes to D.
- Undefined: fixed D-over-IF priority; rr_last logic is not present.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3)
  - requester ID constants (REQ_IF=1'b0, REQ_D=1'b1)
  - MEM_LAT_MAX=8
  - lat_cnt width = clog2(MEM_LAT_MAX)
- One sub-module, arb_pick: purely combinational winner selection from the two valids and rr_last, with the ARB_RR_EN behaviour inside it.

Test Plan:
1. IF read only, MEM_LAT=1, addr 0x0000_0010, memory returns 0xDEAD_BEEF → if_req_ready at T, mem_en at T+1 with mem_addr=0x10, if_rsp_valid pulse at T+3 with data 0xDEAD_BEEF; d_rsp_valid stays 0.
2. D write, addr 0x100, wdata 0x1234_5678, strb 4'b0011 → single mem_en cycle with mem_we=1, strb 0011; d_rsp_valid pulse with d_rsp_data=0.
3. IF and D valid in the same cycle, fixed priority → D granted first, IF granted MEM_LAT+3 cycles later; rsp pulses occur in order D then IF.
4. Same stimulus as 3, held for 4 transactions with ARB_RR_EN defined → grants alternate D, IF, D, IF.
5. MEM_LAT=4, D read, areset pulsed during WAIT → all outputs 0 immediately, no d_rsp_valid ever; the next IF request completes normally with correct data.
6. IF valid dropped before ready (D holds the bus) → no IF transaction issued and no if_rsp_valid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Optional round-robin arbitration is enabled with macro ARB_RR_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    localparam int MEM_LAT_MAX = 8;
    localparam int LAT_W       = $clog2(MEM_LAT_MAX);

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection between IF and D requesters.
// ARB_RR_EN selects round-robin; otherwise D has fixed priority.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_if_valid,
    input  logic i_d_valid,
`ifdef ARB_RR_EN
    input  logic i_rr_last,
`endif
    output logic o_winner
);

`ifdef ARB_RR_EN
    always_comb begin
        o_winner = REQ_IF;
        if (i_if_valid && i_d_valid) begin
            o_winner = ~i_rr_last;
        end else if (i_d_valid) begin
            o_winner = REQ_D;
        end
    end
`else
    // D is the older instruction, so it wins any contention.
    always_comb begin
        o_winner = REQ_IF;
        if (i_d_valid) begin
            o_winner = REQ_D;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port RAM between IF and D requesters.
// Build with ARB_RR_EN defined for round-robin arbitration.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [AW-1:0]   if_req_addr,
    output logic            if_rsp_valid,
    output logic [DW-1:0]   if_rsp_data,
    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic            d_req_we,
    input  logic [DW/8-1:0] d_req_strb,
    input  logic [AW-1:0]   d_req_addr,
    input  logic [DW-1:0]   d_req_wdata,
    output logic            d_rsp_valid,
    output logic [DW-1:0]   d_rsp_data,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_strb,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic            arb_busy
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
            $error("mem_port_arbiter: MEM_LAT must be 1..8");
        end
    endgenerate

    state_t            r_state;
    state_t            w_next;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic              r_owner;
    logic              r_we;
    logic [DW/8-1:0]   r_strb;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_wdata;
    logic [DW-1:0]     r_rsp_data;
    logic              w_winner;
    logic              w_idle;
    logic              w_issue;
    logic              w_hs;
    logic              w_lat_done;

`ifdef ARB_RR_EN
    logic              r_rr_last;
`endif

    arb_pick u_pick (
        .i_if_valid (if_req_valid),
        .i_d_valid  (d_req_valid),
`ifdef ARB_RR_EN
        .i_rr_last  (r_rr_last),
`endif
        .o_winner   (w_winner)
    );

    // Ready is masked during reset so every output reads 0.
    assign w_idle       = (r_state == IDLE) && !areset;
    assign if_req_ready = w_idle && if_req_valid && (w_winner == REQ_IF);
    assign d_req_ready  = w_idle && d_req_valid && (w_winner == REQ_D);
    assign w_hs         = if_req_ready || d_req_ready;
    assign w_issue      = (r_state == ISSUE);
    assign w_lat_done   = (r_state == WAIT) && (r_lat_cnt == '0);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_hs) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (w_lat_done) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_lat_cnt  <= '0;
            r_owner    <= REQ_IF;
            r_we       <= 1'b0;
            r_strb     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
        end else begin
            if (d_req_ready) begin
                r_owner <= REQ_D;
                r_we    <= d_req_we;
                r_strb  <= d_req_strb;
                r_addr  <= d_req_addr;
                r_wdata <= d_req_wdata;
            end else if (if_req_ready) begin
                r_owner <= REQ_IF;
                r_we    <= 1'b0;
                r_strb  <= '0;
                r_addr  <= if_req_addr;
                r_wdata <= '0;
            end
            if (w_issue) begin
                r_lat_cnt <= LAT_W'(MEM_LAT - 1);
            end else if (r_state == WAIT && !w_lat_done) begin
                r_lat_cnt <= r_lat_cnt - LAT_W'(1);
            end
            if (w_lat_done) begin
                r_rsp_data <= r_we ? '0 : mem_rdata;
            end
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rr_last <= REQ_IF;
        end else if (w_hs) begin
            r_rr_last <= w_winner;
        end
    end
`endif

    assign if_rsp_valid = (r_state == RESP) && (r_owner == REQ_IF);
    assign d_rsp_valid  = (r_state == RESP) && (r_owner == REQ_D);
    assign if_rsp_data  = r_rsp_data;
    assign d_rsp_data   = r_rsp_data;

    assign mem_en    = w_issue;
    assign mem_we    = w_issue && r_we;
    assign mem_strb  = w_issue ? r_strb : '0;
    assign mem_addr  = w_issue ? r_addr : '0;
    assign mem_wdata = w_issue ? r_wdata : '0;
    assign arb_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=1 and MEM_LAT=4 instances.
// Contention expectations follow ARB_RR_EN when it is defined.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
    logic [3:0]  d_req_strb, mem_strb;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
    logic        mem_en, mem_we, arb_busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        if_req_valid_4, if_req_ready_4, if_rsp_valid_4;
    logic [31:0] if_req_addr_4, if_rsp_data_4;
    logic        d_req_valid_4, d_req_ready_4, d_req_we_4, d_rsp_valid_4;
    logic [3:0]  d_req_strb_4, mem_strb_4;
    logic [31:0] d_req_addr_4, d_req_wdata_4, d_rsp_data_4;
    logic        mem_en_4, mem_we_4, arb_busy_4;
    logic [31:0] mem_addr_4, mem_wdata_4, mem_rdata_4;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut (
        .aclk(aclk), .areset(areset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_req_addr(if_req_addr), .if_rsp_valid(if_rsp_valid),
        .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
        .d_req_we(d_req_we), .d_req_strb(d_req_strb),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_strb(mem_strb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .arb_busy(arb_busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) u_dut4 (
        .aclk(aclk), .areset(areset),
        .if_req_valid(if_req_valid_4), .if_req_ready(if_req_ready_4),
        .if_req_addr(if_req_addr_4), .if_rsp_valid(if_rsp_valid_4),
        .if_rsp_data(if_rsp_data_4),
        .d_req_valid(d_req_valid_4), .d_req_ready(d_req_ready_4),
        .d_req_we(d_req_we_4), .d_req_strb(d_req_strb_4),
        .d_req_addr(d_req_addr_4), .d_req_wdata(d_req_wdata_4),
        .d_rsp_valid(d_rsp_valid_4), .d_rsp_data(d_rsp_data_4),
        .mem_en(mem_en_4), .mem_we(mem_we_4), .mem_strb(mem_strb_4),
        .mem_addr(mem_addr_4), .mem_wdata(mem_wdata_4),
        .mem_rdata(mem_rdata_4), .arb_busy(arb_busy_4)
    );

    // Memory model: fixed contents, rdata valid MEM_LAT cycles after mem_en.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
    endfunction

    logic        pv1 = 1'b0;
    logic [31:0] pa1 = '0;
    logic        pv4 [4] = '{default: 1'b0};
    logic [31:0] pa4 [4] = '{default: '0};

    always @(posedge aclk) begin
        pv1 <= mem_en;
        pa1 <= mem_addr;
        pv4[0] <= mem_en_4;
        pa4[0] <= mem_addr_4;
        for (int s = 1; s < 4; s++) begin
            pv4[s] <= pv4[s-1];
            pa4[s] <= pa4[s-1];
        end
    end

    assign mem_rdata   = pv1 ? mdata(pa1) : 32'hBAD0_BAD0;
    assign mem_rdata_4 = pv4[3] ? mdata(pa4[3]) : 32'hBAD0_BAD0;

    function automatic logic [138:0] outs1();
        return {if_req_ready, if_rsp_valid, if_rsp_data, d_req_ready,
                d_rsp_valid, d_rsp_data, mem_en, mem_we, mem_strb,
                mem_addr, mem_wdata, arb_busy};
    endfunction

    function automatic logic [138:0] outs4();
        return {if_req_ready_4, if_rsp_valid_4, if_rsp_data_4, d_req_ready_4,
                d_rsp_valid_4, d_rsp_data_4, mem_en_4, mem_we_4, mem_strb_4,
                mem_addr_4, mem_wdata_4, arb_busy_4};
    endfunction

    task automatic test_reset();
        areset = 1'b1;
        if_req_valid = 0; if_req_addr = '0;
        d_req_valid = 0; d_req_we = 0; d_req_strb = '0;
        d_req_addr = '0; d_req_wdata = '0;
        if_req_valid_4 = 0; if_req_addr_4 = '0;
        d_req_valid_4 = 0; d_req_we_4 = 0; d_req_strb_4 = '0;
        d_req_addr_4 = '0; d_req_wdata_4 = '0;
        repeat (2) @(negedge aclk);
        n_cmp++;
        if (outs1() !== '0) begin
            n_bad++;
            $display("FAIL reset_outs1: got %h want 0", outs1());
        end
        n_cmp++;
        if (outs4() !== '0) begin
            n_bad++;
            $display("FAIL reset_outs4: got %h want 0", outs4());
        end
        areset = 1'b0;
        @(negedge aclk);
        n_cmp++;
        if (arb_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: got %b want 0", arb_busy);
        end
    endtask

    task automatic test_priority();
        @(negedge aclk);
        if_req_valid = 1; if_req_addr = 32'h20;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h200;
        #1;
        n_cmp++;
        if ({d_req_ready, if_req_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL prio_ready: got d=%b if=%b want d=1 if=0",
                     d_req_ready, if_req_ready);
        end
        @(negedge aclk);
        d_req_valid = 0;
        n_cmp++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h200) begin
            n_bad++;
            $display("FAIL prio_issue_d: got en=%b addr=%h want 1 200",
                     mem_en, mem_addr);
        end
        repeat (2) @(negedge aclk);
        n_cmp++;
        if (d_rsp_valid !== 1'b1 || if_rsp_valid !== 1'b0
            || d_rsp_data !== 32'hA5A5_0200) begin
            n_bad++;
            $display("FAIL prio_rsp_d: got dv=%b iv=%b data=%h want 1 0 a5a50200",
                     d_rsp_valid, if_rsp_valid, d_rsp_data);
        end
        @(negedge aclk);
        #1;
        n_cmp++;
        if (if_req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL prio_if_ready: got %b want 1", if_req_ready);
        end
        @(negedge aclk);
        if_req_valid = 0;
        n_cmp++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h20) begin
            n_bad++;
            $display("FAIL prio_issue_if: got en=%b addr=%h want 1 20",
                     mem_en, mem_addr);
        end
        repeat (2) @(negedge aclk);
        n_cmp++;
        if (if_rsp_valid !== 1'b1 || d_rsp_valid !== 1'b0
            || if_rsp_data !== 32'hA5A5_0020) begin
            n_bad++;
            $display("FAIL prio_rsp_if: got iv=%b dv=%b data=%h want 1 0 a5a50020",
                     if_rsp_valid, d_rsp_valid, if_rsp_data);
        end
        @(negedge aclk);
    endtask

    task automatic test_contended();
        logic exp_d [4];
`ifdef ARB_RR_EN
        exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        @(negedge aclk);
        if_req_valid = 1; if_req_addr = 32'h24;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h204;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (d_req_ready !== exp_d[k] || if_req_ready !== !exp_d[k]) begin
                n_bad++;
                $display("FAIL cont_grant%0d: got d=%b if=%b want d=%b",
                         k, d_req_ready, if_req_ready, exp_d[k]);
            end
            repeat (3) @(negedge aclk);
            n_cmp++;
            if (d_rsp_valid !== exp_d[k] || if_rsp_valid !== !exp_d[k]) begin
                n_bad++;
                $display("FAIL cont_rsp%0d: got dv=%b iv=%b want dv=%b",
                         k, d_rsp_valid, if_rsp_valid, exp_d[k]);
            end
            @(negedge aclk);
        end
        if_req_valid = 0;
        d_req_valid = 0;
        @(negedge aclk);
        n_cmp++;
        if (arb_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL cont_idle: got busy=%b want 0", arb_busy);
        end
    endtask

    task automatic test_if_read();
        @(negedge aclk);
        if_req_valid = 1; if_req_addr = 32'h10;
        #1;
        n_cmp++;
        if (if_req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL if_ready: got %b want 1", if_req_ready);
        end
        @(negedge aclk);
        if_req_valid = 0;
        n_cmp++;
        if ({mem_en, mem_we, mem_strb, mem_addr} !== {1'b1, 1'b0, 4'h0, 32'h10}) begin
            n_bad++;
            $display("FAIL if_issue: got en=%b we=%b strb=%h addr=%h want 1 0 0 10",
                     mem_en, mem_we, mem_strb, mem_addr);
        end
        @(negedge aclk);
        n_cmp++;
        if (mem_en !== 1'b0) begin
            n_bad++;
            $display("FAIL if_en_once: got %b want 0", mem_en);
        end
        @(negedge aclk);
        n_cmp++;
        if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'hDEAD_BEEF
            || d_rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL if_rsp: got iv=%b data=%h dv=%b want 1 deadbeef 0",
                     if_rsp_valid, if_rsp_data, d_rsp_valid);
        end
        @(negedge aclk);
        n_cmp++;
        if (if_rsp_valid !== 1'b0 || arb_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL if_done: got iv=%b busy=%b want 0 0",
                     if_rsp_valid, arb_busy);
        end
    endtask

    task automatic test_d_write();
        @(negedge aclk);
        d_req_valid = 1; d_req_we = 1; d_req_strb = 4'b0011;
        d_req_addr = 32'h100; d_req_wdata = 32'h1234_5678;
        #1;
        n_cmp++;
        if (d_req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL dw_ready: got %b want 1", d_req_ready);
        end
        @(negedge aclk);
        d_req_valid = 0;
        n_cmp++;
        if ({mem_en, mem_we, mem_strb, mem_addr, mem_wdata}
            !== {1'b1, 1'b1, 4'b0011, 32'h100, 32'h1234_5678}) begin
            n_bad++;
            $display("FAIL dw_issue: got en=%b we=%b strb=%b addr=%h wd=%h",
                     mem_en, mem_we, mem_strb, mem_addr, mem_wdata);
        end
        @(negedge aclk);
        n_cmp++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL dw_en_once: got en=%b we=%b want 0 0", mem_en, mem_we);
        end
        @(negedge aclk);
        n_cmp++;
        if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h0
            || if_rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL dw_rsp: got dv=%b data=%h iv=%b want 1 0 0",
                     d_rsp_valid, d_rsp_data, if_rsp_valid);
        end
        d_req_we = 0; d_req_strb = '0; d_req_wdata = '0;
        @(negedge aclk);
        n_cmp++;
        if (d_rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL dw_pulse: got %b want 0", d_rsp_valid);
        end
    endtask

    task automatic test_if_drop();
        int en_cnt, irsp, drsp;
        irsp = 0;
        drsp = 0;
        @(negedge aclk);
        d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h208;
        #1;
        n_cmp++;
        if (d_req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_d_ready: got %b want 1", d_req_ready);
        end
        @(negedge aclk);
        d_req_valid = 0;
        if_req_valid = 1; if_req_addr = 32'h30;
        #1;
        n_cmp++;
        if (if_req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_if_ready: got %b want 0", if_req_ready);
        end
        en_cnt = int'(mem_en);
        @(negedge aclk);
        if_req_valid = 0;
        for (int i = 0; i < 7; i++) begin
            en_cnt += int'(mem_en);
            irsp += int'(if_rsp_valid);
            drsp += int'(d_rsp_valid);
            @(negedge aclk);
        end
        n_cmp++;
        if (en_cnt != 1 || irsp != 0 || drsp != 1) begin
            n_bad++;
            $display("FAIL drop_counts: got en=%0d irsp=%0d drsp=%0d want 1 0 1",
                     en_cnt, irsp, drsp);
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        cnt = 0;
        @(negedge aclk);
        d_req_valid_4 = 1; d_req_we_4 = 0; d_req_addr_4 = 32'h40;
        #1;
        n_cmp++;
        if (d_req_ready_4 !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_ready: got %b want 1", d_req_ready_4);
        end
        @(negedge aclk);
        d_req_valid_4 = 0;
        n_cmp++;
        if (mem_en_4 !== 1'b1 || mem_addr_4 !== 32'h40) begin
            n_bad++;
            $display("FAIL rm_issue: got en=%b addr=%h want 1 40",
                     mem_en_4, mem_addr_4);
        end
        @(negedge aclk);
        n_cmp++;
        if (arb_busy_4 !== 1'b1 || mem_en_4 !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_wait: got busy=%b en=%b want 1 0",
                     arb_busy_4, mem_en_4);
        end
        @(negedge aclk);
        areset = 1'b1;
        #1;
        n_cmp++;
        if (outs4() !== '0) begin
            n_bad++;
            $display("FAIL rm_reset_outs: got %h want 0", outs4());
        end
        @(negedge aclk);
        areset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cnt += int'(d_rsp_valid_4);
            @(negedge aclk);
        end
        n_cmp++;
        if (cnt != 0) begin
            n_bad++;
            $display("FAIL rm_no_rsp: got %0d pulses want 0", cnt);
        end
        if_req_valid_4 = 1; if_req_addr_4 = 32'h10;
        #1;
        n_cmp++;
        if (if_req_ready_4 !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_if_ready: got %b want 1", if_req_ready_4);
        end
        @(negedge aclk);
        if_req_valid_4 = 0;
        n_cmp++;
        if (mem_en_4 !== 1'b1 || mem_addr_4 !== 32'h10) begin
            n_bad++;
            $display("FAIL rm_if_issue: got en=%b addr=%h want 1 10",
                     mem_en_4, mem_addr_4);
        end
        repeat (4) @(negedge aclk);
        n_cmp++;
        if (if_rsp_valid_4 !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_if_early: got %b want 0", if_rsp_valid_4);
        end
        @(negedge aclk);
        n_cmp++;
        if (if_rsp_valid_4 !== 1'b1 || if_rsp_data_4 !== 32'hDEAD_BEEF
            || d_rsp_valid_4 !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_if_rsp: got iv=%b data=%h dv=%b want 1 deadbeef 0",
                     if_rsp_valid_4, if_rsp_data_4, d_rsp_valid_4);
        end
        @(negedge aclk);
        n_cmp++;
        if (arb_busy_4 !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_idle: got busy=%b want 0", arb_busy_4);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_contended();
        test_if_read();
        test_d_write();
        test_if_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
